// File: rtl/xctcmsg_bus_hub_pkg.sv
// Shared types and helpers for the xctcmsg bus hub: hart-id width, default
// send/receive record layouts and a modulo pointer increment.
package xctcmsg_bus_hub_pkg;

  localparam int XCTCMSG_HARTID_WIDTH = 32;
  localparam int XCTCMSG_MSG_WIDTH    = 64;

  typedef struct packed {
    logic [XCTCMSG_HARTID_WIDTH-1:0] dst;
    logic [31:0]                     tag;
    logic [XCTCMSG_MSG_WIDTH-1:0]    msg;
  } bus_send_data_t;

  typedef struct packed {
    logic [XCTCMSG_HARTID_WIDTH-1:0] src;
    logic [31:0]                     tag;
    logic [XCTCMSG_MSG_WIDTH-1:0]    msg;
  } bus_receive_data_t;

  // Pointers wrap at the real depth, which need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p + 1 >= depth) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/xctcmsg_bus_hub_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant_i, with wrap.
// Purely combinational; no state, so the caller owns the grant pointer.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_vld_o
);

  int c;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    c           = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_grant_i) + k) % N;
      if (!grant_vld_o && req_i[c]) begin
        grant_vld_o   = 1'b1;
        grant_oh_o[c] = 1'b1;
        grant_idx_o   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/xctcmsg_bus_hub.sv
// Bus hub: round-robin N-channel sender into a one-entry held slot, plus an
// RX_DEPTH receive FIFO. Optional counters under XCTCMSG_BUS_HUB_STATS_EN.
module xctcmsg_bus_hub
  import xctcmsg_bus_hub_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int MSG_WIDTH    = 64,
  parameter int RX_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHANNELS-1:0]        tx_valid_i,
  output logic [NUM_CHANNELS-1:0]        tx_ready_o,
  input  logic [NUM_CHANNELS*32-1:0]     tx_dst_i,
  input  logic [NUM_CHANNELS*32-1:0]     tx_tag_i,
  input  logic [NUM_CHANNELS*MSG_WIDTH-1:0] tx_msg_i,
  output logic                           bus_val_o,
  input  logic                           bus_ack_i,
  output logic [31:0]                    bus_dst_o,
  output logic [31:0]                    bus_tag_o,
  output logic [MSG_WIDTH-1:0]           bus_msg_o,
  output logic                           bus_rdy_o,
  input  logic                           bus_val_i,
  input  logic [31:0]                    bus_src_i,
  input  logic [31:0]                    bus_tag_i,
  input  logic [MSG_WIDTH-1:0]           bus_msg_i,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic [31:0]                    rx_src_o,
  output logic [31:0]                    rx_tag_o,
  output logic [MSG_WIDTH-1:0]           rx_msg_o
`ifdef XCTCMSG_BUS_HUB_STATS_EN
  , output logic [31:0]                  tx_count_o
  , output logic [31:0]                  rx_count_o
`endif
);

  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam int HW = XCTCMSG_HARTID_WIDTH;

  typedef struct packed {
    logic [HW-1:0]        dst;
    logic [31:0]          tag;
    logic [MSG_WIDTH-1:0] msg;
  } send_t;

  typedef struct packed {
    logic [HW-1:0]        src;
    logic [31:0]          tag;
    logic [MSG_WIDTH-1:0] msg;
  } recv_t;

  typedef enum logic {SLOT_EMPTY, SLOT_HELD} slot_e;

  slot_e           slot_q, slot_d;
  send_t           snd_q, snd_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NUM_CHANNELS-1:0] grant_oh;
  logic [IW-1:0]   grant_idx;
  logic            grant_vld;
  logic            slot_free;
  logic            accept;
  int              gi;

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req_i        (tx_valid_i),
    .last_grant_i (last_q),
    .grant_oh_o   (grant_oh),
    .grant_idx_o  (grant_idx),
    .grant_vld_o  (grant_vld)
  );

  // An ack this cycle frees the slot, so a new message can follow with no bubble.
  always_comb begin
    slot_free  = (slot_q == SLOT_EMPTY) || bus_ack_i;
    tx_ready_o = slot_free ? grant_oh : '0;
    accept     = slot_free && grant_vld;
    gi         = int'(grant_idx);
    slot_d     = slot_q;
    snd_d      = snd_q;
    last_d     = last_q;
    if (accept) begin
      slot_d    = SLOT_HELD;
      snd_d.dst = tx_dst_i[gi*32 +: 32];
      snd_d.tag = tx_tag_i[gi*32 +: 32];
      snd_d.msg = tx_msg_i[gi*MSG_WIDTH +: MSG_WIDTH];
      last_d    = grant_idx;
    end else if (slot_q == SLOT_HELD && bus_ack_i) begin
      slot_d = SLOT_EMPTY;
    end
  end

  assign bus_val_o = (slot_q == SLOT_HELD);
  assign bus_dst_o = snd_q.dst;
  assign bus_tag_o = snd_q.tag;
  assign bus_msg_o = snd_q.msg;

  recv_t         mem_q [RX_DEPTH];
  recv_t         mem_d [RX_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  // Ready comes from the registered count only, so a full FIFO cannot take a
  // push in the same cycle it is popped.
  assign bus_rdy_o  = (cnt_q < CW'(RX_DEPTH));
  assign rx_valid_o = (cnt_q != '0);
  assign rx_src_o   = mem_q[rptr_q].src;
  assign rx_tag_o   = mem_q[rptr_q].tag;
  assign rx_msg_o   = mem_q[rptr_q].msg;

  always_comb begin
    push   = bus_val_i && bus_rdy_o;
    pop    = rx_valid_o && rx_ready_i;
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = '{src: bus_src_i, tag: bus_tag_i, msg: bus_msg_i};
      wptr_d        = PW'(wrap_inc(32'(wptr_q), RX_DEPTH));
    end
    if (pop) begin
      rptr_d = PW'(wrap_inc(32'(rptr_q), RX_DEPTH));
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
      snd_q  <= '0;
      last_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
      snd_q  <= snd_d;
      last_q <= last_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

`ifdef XCTCMSG_BUS_HUB_STATS_EN
  logic [31:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_cnt_q + ((bus_val_o && bus_ack_i) ? 32'd1 : 32'd0);
    rx_cnt_d = rx_cnt_q + (push ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_count_o = tx_cnt_q;
  assign rx_count_o = rx_cnt_q;
`else
  // Default build carries no traffic counters.
`endif

endmodule
